// File: rtl/uart_msg_sender.sv
// Framed message transmitter for the pong board link: SOF, header, payload, XOR checksum
// on UART 8N1 (LSB first), gated by clear-to-send, with optional ack and retransmit.
module uart_msg_sender #(
    parameter int CLK_HZ        = 50000000,
    parameter int BAUD          = 115200,
    parameter int PAYLOAD_BYTES = 2,
    parameter int ACK_TIMEOUT   = 2000000,
    parameter int MAX_RETRIES   = 3
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       send_new_message,
    input  logic [3:0]                 msg_type,
    input  logic [3:0]                 msg_len,
    input  logic [8*PAYLOAD_BYTES-1:0] msg_payload,
    input  logic                       need_ack,
    input  logic                       ack_received,
    input  logic                       tx_allow,
    output logic                       ready,
    output logic                       message_sent,
    output logic                       ack_failed,
    output logic                       UART_TXD,
    output logic [2:0]                 o_dbg_state
);
    localparam int DIV     = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int BAUD_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int ACK_W   = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam int RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam logic [7:0] SOF = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_CTS = 3'd1,
        S_START    = 3'd2,
        S_DATA     = 3'd3,
        S_STOP     = 3'd4,
        S_WAIT_ACK = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    state_t                     r_state;
    logic [3:0]                 r_type;
    logic [3:0]                 r_len;
    logic [8*PAYLOAD_BYTES-1:0] r_payload;
    logic                       r_need_ack;
    logic [7:0]                 r_cksum;
    logic [4:0]                 r_byte_idx;
    logic [2:0]                 r_bit_idx;
    logic [BAUD_W-1:0]          r_baud_cnt;
    logic [ACK_W-1:0]           r_ack_cnt;
    logic [RETRY_W-1:0]         r_retry;
    logic [7:0]                 r_shift;
    logic                       r_txd;
    logic                       r_ready;
    logic                       r_sent;
    logic                       r_fail;

    logic [3:0]                 w_len_clamped;
    logic [7:0]                 w_cksum_in;
    logic [4:0]                 w_next_idx;
    logic [7:0]                 w_cur_byte;
    logic [7:0]                 w_next_byte;
    logic                       w_baud_end;
    logic                       w_ack_end;
    logic                       w_last_byte;

    // Byte idx of the frame: 0 = SOF, 1 = header, 2..len+1 = payload (MSB first), then checksum.
    function automatic logic [7:0] frame_byte(
        input logic [4:0]                 idx,
        input logic [3:0]                 typ,
        input logic [3:0]                 len,
        input logic [8*PAYLOAD_BYTES-1:0] pay,
        input logic [7:0]                 ck
    );
        logic [7:0] b;
        b = ck;
        if (idx == 5'd0) begin
            b = SOF;
        end else if (idx == 5'd1) begin
            b = {typ, len};
        end else begin
            for (int i = 0; i < PAYLOAD_BYTES; i++) begin
                if (({1'b0, len} > 5'(i)) && (idx == 5'(i + 2))) begin
                    b = pay[8*(PAYLOAD_BYTES-1-i) +: 8];
                end
            end
        end
        return b;
    endfunction

    always_comb begin
        w_len_clamped = (msg_len > 4'(PAYLOAD_BYTES)) ? 4'(PAYLOAD_BYTES) : msg_len;
        w_cksum_in    = {msg_type, w_len_clamped};
        for (int i = 0; i < PAYLOAD_BYTES; i++) begin
            if (w_len_clamped > 4'(i)) begin
                w_cksum_in = w_cksum_in ^ msg_payload[8*(PAYLOAD_BYTES-1-i) +: 8];
            end
        end
    end

    assign w_next_idx  = r_byte_idx + 5'd1;
    assign w_cur_byte  = frame_byte(r_byte_idx, r_type, r_len, r_payload, r_cksum);
    assign w_next_byte = frame_byte(w_next_idx, r_type, r_len, r_payload, r_cksum);
    assign w_baud_end  = (r_baud_cnt == BAUD_W'(DIV - 1));
    assign w_ack_end   = (r_ack_cnt == ACK_W'(ACK_TIMEOUT - 1));
    assign w_last_byte = (r_byte_idx == ({1'b0, r_len} + 5'd2));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_type     <= '0;
            r_len      <= '0;
            r_payload  <= '0;
            r_need_ack <= 1'b0;
            r_cksum    <= '0;
            r_byte_idx <= '0;
            r_bit_idx  <= '0;
            r_baud_cnt <= '0;
            r_ack_cnt  <= '0;
            r_retry    <= '0;
            r_shift    <= '0;
            r_txd      <= 1'b1;
            r_ready    <= 1'b1;
            r_sent     <= 1'b0;
            r_fail     <= 1'b0;
        end else begin
            r_sent <= 1'b0;
            r_fail <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (send_new_message) begin
                        r_type     <= msg_type;
                        r_len      <= w_len_clamped;
                        r_payload  <= msg_payload;
                        r_need_ack <= need_ack;
                        r_cksum    <= w_cksum_in;
                        r_ready    <= 1'b0;
                        r_retry    <= '0;
                        r_byte_idx <= '0;
                        r_baud_cnt <= '0;
                        // Acceptance is a byte boundary, so clear-to-send is sampled here too.
                        if (tx_allow) begin
                            r_state <= S_START;
                            r_txd   <= 1'b0;
                            r_shift <= SOF;
                        end else begin
                            r_state <= S_WAIT_CTS;
                        end
                    end
                end
                S_WAIT_CTS: begin
                    if (tx_allow) begin
                        r_state    <= S_START;
                        r_txd      <= 1'b0;
                        r_shift    <= w_cur_byte;
                        r_baud_cnt <= '0;
                    end
                end
                S_START: begin
                    if (w_baud_end) begin
                        r_baud_cnt <= '0;
                        r_txd      <= r_shift[0];
                        r_shift    <= r_shift >> 1;
                        r_bit_idx  <= '0;
                        r_state    <= S_DATA;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_baud_end) begin
                        r_baud_cnt <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_txd   <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            r_txd     <= r_shift[0];
                            r_shift   <= r_shift >> 1;
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_baud_end) begin
                        r_baud_cnt <= '0;
                        if (w_last_byte) begin
                            if (r_need_ack) begin
                                r_ack_cnt <= '0;
                                r_state   <= S_WAIT_ACK;
                            end else begin
                                r_sent  <= 1'b1;
                                r_state <= S_DONE;
                            end
                        end else begin
                            r_byte_idx <= w_next_idx;
                            if (tx_allow) begin
                                r_state <= S_START;
                                r_txd   <= 1'b0;
                                r_shift <= w_next_byte;
                            end else begin
                                r_state <= S_WAIT_CTS;
                            end
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                S_WAIT_ACK: begin
                    // Ack is checked first so that it wins over a coincident timeout.
                    if (ack_received) begin
                        r_sent  <= 1'b1;
                        r_state <= S_DONE;
                    end else if (w_ack_end) begin
                        if (r_retry == RETRY_W'(MAX_RETRIES)) begin
                            r_fail  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_retry    <= r_retry + 1'b1;
                            r_byte_idx <= '0;
                            r_baud_cnt <= '0;
                            if (tx_allow) begin
                                r_state <= S_START;
                                r_txd   <= 1'b0;
                                r_shift <= SOF;
                            end else begin
                                r_state <= S_WAIT_CTS;
                            end
                        end
                    end else begin
                        r_ack_cnt <= r_ack_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_txd   <= 1'b1;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ready        = r_ready;
    assign message_sent = r_sent;
    assign ack_failed   = r_fail;
    assign UART_TXD     = r_txd;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_uart_msg_sender.sv
// Directed bench for uart_msg_sender: decodes the serial line and compares framing,
// byte values and cycle-exact timing against hand-computed frames.
module tb_uart_msg_sender;
  localparam int DIV    = 10;
  localparam int ACK_TO = 1000;

  // Handshake: a request is taken on a rising clock edge where send_new_message=1 and ready=1;
  // ready falls the next cycle and nothing is queued while it is low.
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        send_new_message = 1'b0;
  logic [3:0]  msg_type = '0;
  logic [3:0]  msg_len = '0;
  logic [15:0] msg_payload = '0;
  logic        need_ack = 1'b0;
  logic        ack_received = 1'b0;
  logic        tx_allow = 1'b1;
  logic        ready;
  logic        message_sent;
  logic        ack_failed;
  logic        UART_TXD;
  logic [2:0]  o_dbg_state;

  uart_msg_sender #(
    .CLK_HZ(1000000), .BAUD(100000), .PAYLOAD_BYTES(2), .ACK_TIMEOUT(ACK_TO), .MAX_RETRIES(3)
  ) dut (
    .clock(clock), .reset(reset), .send_new_message(send_new_message), .msg_type(msg_type),
    .msg_len(msg_len), .msg_payload(msg_payload), .need_ack(need_ack),
    .ack_received(ack_received), .tx_allow(tx_allow), .ready(ready),
    .message_sent(message_sent), .ack_failed(ack_failed), .UART_TXD(UART_TXD),
    .o_dbg_state(o_dbg_state)
  );

  // clock/reset block
  always #5 clock = ~clock;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int cnt_sent = 0;
  int cnt_fail = 0;
  int cnt_both = 0;
  always @(negedge clock) begin
    if (message_sent === 1'b1) cnt_sent <= cnt_sent + 1;
    if (ack_failed === 1'b1) cnt_fail <= cnt_fail + 1;
    if (message_sent === 1'b1 && ack_failed === 1'b1) cnt_both <= cnt_both + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // scoreboard
  logic [7:0] exp_q[$];
  int n_asserts = 0;
  int n_fail = 0;
  int t_acc, t_byte_start, t_frame_start, t_frame_end;

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send(input logic [3:0] t, input logic [3:0] l, input logic [15:0] p,
                      input logic na);
    check1("send_ready_high", ready, 1'b1);
    msg_type = t;
    msg_len = l;
    msg_payload = p;
    need_ack = na;
    send_new_message = 1'b1;
    tick(1);
    send_new_message = 1'b0;
    t_acc = cyc;
    check1("send_ready_low", ready, 1'b0);
  endtask

  task automatic wait_start(input string tag, output int t);
    int n = 0;
    while (UART_TXD !== 1'b0 && n < 4000) begin
      tick(1);
      n++;
    end
    t = cyc;
    check1({tag, "_start_seen"}, UART_TXD, 1'b0);
  endtask

  // action: 0 none, 1 drop tx_allow inside the start bit, 2 pulse ack_received inside it
  task automatic rx_byte_chk(input string tag, input logic [7:0] exp, input int action);
    logic [7:0] b;
    logic start_bit, stop_bit;
    int t;
    wait_start(tag, t);
    t_byte_start = t;
    if (action == 1) tx_allow = 1'b0;
    if (action == 2) begin
      ack_received = 1'b1;
      tick(1);
      ack_received = 1'b0;
      tick(DIV / 2 - 1);
    end else begin
      tick(DIV / 2);
    end
    start_bit = UART_TXD;
    for (int i = 0; i < 8; i++) begin
      tick(DIV);
      b[i] = UART_TXD;
    end
    tick(DIV);
    stop_bit = UART_TXD;
    check8({tag, "_data"}, b, exp);
    check8({tag, "_framing"}, {6'b0, start_bit, stop_bit}, 8'd1);
  endtask

  task automatic rx_frame(input string tag);
    foreach (exp_q[i]) begin
      rx_byte_chk($sformatf("%s_b%0d", tag, i), exp_q[i], 0);
      if (i == 0) t_frame_start = t_byte_start;
    end
    t_frame_end = cyc + DIV / 2;
  endtask

  task automatic wait_sent(input string tag, output int t);
    int n = 0;
    while (message_sent !== 1'b1 && n < 3000) begin
      tick(1);
      n++;
    end
    t = cyc;
    check1({tag, "_sent"}, message_sent, 1'b1);
    check1({tag, "_sent_no_fail"}, ack_failed, 1'b0);
  endtask

  task automatic idle_watch(input int n, output int lows);
    lows = 0;
    for (int i = 0; i < n; i++) begin
      tick(1);
      if (UART_TXD !== 1'b1) lows++;
    end
  endtask

  initial begin
    int t, r, lows, s_sent, s_fail, prev_end;

    // reset state
    tick(3);
    check1("rst_txd", UART_TXD, 1'b1);
    check1("rst_ready", ready, 1'b1);
    check1("rst_sent", message_sent, 1'b0);
    check1("rst_fail", ack_failed, 1'b0);
    check8("rst_state", {5'b0, o_dbg_state}, 8'd0);
    reset = 1'b1;
    tick(2);

    // 1: type 1, len 2, payload 1234 -> A5 12 12 34 34, 50 bits of 10 cycles
    s_sent = cnt_sent;
    send(4'd1, 4'd2, 16'h1234, 1'b0);
    exp_q = '{8'hA5, 8'h12, 8'h12, 8'h34, 8'h34};
    rx_frame("t1");
    check32("t1_start_latency", t_frame_start - t_acc, 0);
    wait_sent("t1", t);
    check32("t1_sent_time", t - t_acc, 500);
    check1("t1_ready_during_pulse", ready, 1'b0);
    tick(1);
    check1("t1_ready_after", ready, 1'b1);
    check1("t1_pulse_one_cycle", message_sent, 1'b0);
    check32("t1_sent_count", cnt_sent - s_sent, 1);

    // 2: len 0 -> A5 30 30; then len 9 clamps to 2 -> A5 22 AB CD 44
    send(4'd3, 4'd0, 16'hFFFF, 1'b0);
    exp_q = '{8'hA5, 8'h30, 8'h30};
    rx_frame("t2");
    wait_sent("t2", t);
    check32("t2_sent_time", t - t_acc, 300);
    tick(1);
    send(4'd2, 4'd9, 16'hABCD, 1'b0);
    exp_q = '{8'hA5, 8'h22, 8'hAB, 8'hCD, 8'h44};
    rx_frame("t2c");
    wait_sent("t2c", t);
    tick(1);

    // 3: clear-to-send held low, then dropped during byte 2 -> A5 51 77 26
    tx_allow = 1'b0;
    send(4'd5, 4'd1, 16'h7700, 1'b0);
    idle_watch(100, lows);
    check32("t3_hold_low_bits", lows, 0);
    check8("t3_state_wait_cts", {5'b0, o_dbg_state}, 8'd1);
    tx_allow = 1'b1;
    r = cyc;
    rx_byte_chk("t3_b0", 8'hA5, 0);
    check32("t3_cts_latency0", t_byte_start - r, 1);
    rx_byte_chk("t3_b1", 8'h51, 1);
    idle_watch(60, lows);
    check32("t3_byte3_held", lows, 0);
    check1("t3_ready_low", ready, 1'b0);
    tx_allow = 1'b1;
    r = cyc;
    rx_byte_chk("t3_b2", 8'h77, 0);
    check32("t3_cts_latency2", t_byte_start - r, 1);
    rx_byte_chk("t3_b3", 8'h26, 0);
    wait_sent("t3", t);
    tick(1);

    // 4: ack during transmission ignored, ack 50 cycles into WAIT_ACK completes -> A5 41 55 14
    s_sent = cnt_sent;
    send(4'd4, 4'd1, 16'h5500, 1'b1);
    rx_byte_chk("t4_b0", 8'hA5, 0);
    rx_byte_chk("t4_b1", 8'h41, 2);
    rx_byte_chk("t4_b2", 8'h55, 0);
    rx_byte_chk("t4_b3", 8'h14, 0);
    check1("t4_no_early_sent", message_sent, 1'b0);
    tick(55);
    ack_received = 1'b1;
    tick(1);
    ack_received = 1'b0;
    check1("t4_ack_sent", message_sent, 1'b1);
    check1("t4_ack_no_fail", ack_failed, 1'b0);
    tick(1);
    check1("t4_ready", ready, 1'b1);
    idle_watch(1100, lows);
    check32("t4_no_retransmit", lows, 0);
    check32("t4_sent_count", cnt_sent - s_sent, 1);

    // 4b: ack on the exact timeout cycle wins -> A5 40 40
    send(4'd4, 4'd0, 16'h0000, 1'b1);
    exp_q = '{8'hA5, 8'h40, 8'h40};
    rx_frame("t4b");
    tick(t_frame_end + ACK_TO - 1 - cyc);
    ack_received = 1'b1;
    tick(1);
    ack_received = 1'b0;
    check1("t4b_ack_sent", message_sent, 1'b1);
    check1("t4b_ack_no_fail", ack_failed, 1'b0);
    idle_watch(300, lows);
    check32("t4b_no_retransmit", lows, 0);
    check8("t4b_state_idle", {5'b0, o_dbg_state}, 8'd0);

    // 5: no ack -> 4 identical frames 1000 idle cycles apart, then ack_failed
    s_sent = cnt_sent;
    s_fail = cnt_fail;
    send(4'd6, 4'd2, 16'hBEEF, 1'b1);
    exp_q = '{8'hA5, 8'h62, 8'hBE, 8'hEF, 8'h33};
    prev_end = 0;
    for (int k = 0; k < 4; k++) begin
      rx_frame($sformatf("t5_f%0d", k));
      if (k > 0) check32($sformatf("t5_gap%0d", k), t_frame_start - prev_end, ACK_TO);
      prev_end = t_frame_end;
    end
    begin
      int n = 0;
      while (ack_failed !== 1'b1 && n < 2000) begin
        tick(1);
        n++;
      end
    end
    check1("t5_fail_pulse", ack_failed, 1'b1);
    check1("t5_fail_no_sent", message_sent, 1'b0);
    check32("t5_fail_time", cyc - prev_end, ACK_TO);
    tick(1);
    check1("t5_fail_one_cycle", ack_failed, 1'b0);
    idle_watch(1200, lows);
    check32("t5_no_fifth_frame", lows, 0);
    check32("t5_fail_count", cnt_fail - s_fail, 1);
    check32("t5_sent_count", cnt_sent - s_sent, 0);

    // 6: busy request ignored, async reset mid payload bit, then a clean frame
    send(4'd1, 4'd2, 16'h1234, 1'b0);
    msg_type = 4'd7;
    msg_len = 4'd0;
    send_new_message = 1'b1;
    tick(1);
    send_new_message = 1'b0;
    rx_byte_chk("t6_b0", 8'hA5, 0);
    rx_byte_chk("t6_b1", 8'h12, 0);
    wait_start("t6_b2", t);
    tick(15);
    check1("t6_mid_bit_low", UART_TXD, 1'b0);
    #2 reset = 1'b0;
    #1;
    check1("t6_async_txd", UART_TXD, 1'b1);
    check1("t6_async_ready", ready, 1'b1);
    check8("t6_async_state", {5'b0, o_dbg_state}, 8'd0);
    tick(3);
    reset = 1'b1;
    idle_watch(20, lows);
    check32("t6_no_resume", lows, 0);
    send(4'd3, 4'd0, 16'h0000, 1'b0);
    exp_q = '{8'hA5, 8'h30, 8'h30};
    rx_frame("t6_new");
    check32("t6_new_latency", t_frame_start - t_acc, 0);
    wait_sent("t6_new", t);
    check32("t6_new_sent_time", t - t_acc, 300);
    tick(2);
    check32("never_both_pulses", cnt_both, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_msg_sender.md
Name: uart_msg_sender

Overview:
Parametrised next-generation message transmitter for board-to-board pong link.
- Accepts one typed message per producer handshake and frames it as SOF, header, payload bytes, checksum.
- Serialises the frame on UART 8N1, LSB first, honouring a clear-to-send input.
- Optionally waits for a remote acknowledge, retransmitting on timeout up to a retry limit.
- Sits between game-control FSM and the UART_TXD pin.

Parameters:
CLK_HZ, 50000000, clock frequency in Hz
BAUD, 115200, line rate; bit period DIV = round(CLK_HZ/BAUD) cycles (434 at defaults)
PAYLOAD_BYTES, 2, maximum payload bytes (1..15)
ACK_TIMEOUT, 2000000, cycles waited in WAIT_ACK before retransmit
MAX_RETRIES, 3, retransmissions after first attempt (total frames = 1+MAX_RETRIES)

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-low reset
send_new_message  input  1  producer request; accepted only when ready=1
msg_type  input  4  message type (ball, miss, new game, new-game ack, ...)
msg_len  input  4  payload byte count; values >PAYLOAD_BYTES clamp to PAYLOAD_BYTES
msg_payload  input  8*PAYLOAD_BYTES  payload, byte 0 = most-significant byte, sent first
need_ack  input  1  1 = frame requires remote ack
ack_received  input  1  one-cycle pulse from receiver: ack seen
tx_allow  input  1  clear-to-send, active-high
ready  output  1  idle and able to accept a message
message_sent  output  1  one-cycle pulse: message completed (and acked if need_ack)
ack_failed  output  1  one-cycle pulse: retries exhausted without ack
UART_TXD  output  1  serial line, idle high

Behaviour:
- Reset (async, reset=0): UART_TXD=1, ready=1, message_sent=0, ack_failed=0, state IDLE, all counters 0. Reset mid-frame aborts immediately; no partial frame resumes.
- Accept: in IDLE with send_new_message=1 at a clock edge, latch type, clamped len, payload, need_ack. Then ready=0 from next cycle. Requests while ready=0 are ignored; there is no queue.
- Frame bytes, in order:
  - 0xA5
  - header {msg_type, len}
  - len payload bytes
  - checksum = XOR of header and all payload bytes (SOF excluded)
- len=0 gives a 3-byte frame.
- States: IDLE -> WAIT_CTS -> START -> DATA(8 bits) -> STOP -> (next byte: WAIT_CTS | last byte: need_ack ? WAIT_ACK : DONE) -> IDLE.
- Each START, DATA and STOP bit drives UART_TXD for exactly DIV cycles. First start bit begins the cycle after acceptance if tx_allow=1.
- WAIT_CTS:
  - tx_allow is sampled only at byte boundaries.
  - tx_allow=0 holds UART_TXD=1 until tx_allow=1.
  - Deassertion mid-byte does not interrupt that byte.
- DONE: pulse message_sent for 1 cycle, then IDLE with ready=1 on the following cycle.
- WAIT_ACK:
  - UART_TXD=1; timeout counter counts ACK_TIMEOUT cycles.
  - ack_received=1: pulse message_sent, go to IDLE.
  - Timeout with retry count < MAX_RETRIES: increment count, retransmit whole frame from SOF via WAIT_CTS.
  - Timeout with count = MAX_RETRIES: pulse ack_failed, go to IDLE.
  - ack_received on the same cycle as timeout expiry: ack wins.
- ack_received outside WAIT_ACK is ignored; it is not remembered.
- message_sent and ack_failed are never asserted together.

Test Plan:
1. Defaults, type=1, len=2, payload=0x1234, need_ack=0, tx_allow=1:
   - TXD carries A5, 12, 12, 34, 34 (checksum 0x12^0x12^0x34=0x34), each bit 434 cycles, 21700 cycles total.
   - message_sent pulses once after final stop bit; ready=1 next cycle.
2. len=0, type=3:
   - Frame A5, 30, 30; message_sent after 13020 cycles.
   - Also drive len=9 with PAYLOAD_BYTES=2: header low nibble = 2.
3. tx_allow=0 at acceptance for 1000 cycles:
   - TXD stays 1 and the start bit begins within 1 cycle of tx_allow rising.
   - Drop tx_allow mid-byte 2: byte 2 completes, byte 3 waits.
4. need_ack=1, ack_received pulse 500 cycles into WAIT_ACK:
   - message_sent pulses, no retransmit.
   - Ack pulse during transmission ignored; ack on exact timeout cycle suppresses retransmit.
5. need_ack=1, no ack, ACK_TIMEOUT=1000:
   - Exactly 4 identical frames, each separated by 1000 idle cycles.
   - ack_failed pulses once; message_sent never asserts.
6. Assert reset mid-payload bit:
   - UART_TXD=1 asynchronously, ready=1.
   - send_new_message while busy earlier is ignored; new request after reset produces a clean full frame.
